usb_in_ep_buffer: RTL

Single-packet IN endpoint buffer and handshake sequencer feeding the USB full-speed transmitter. Endpoint logic loads one packet of bytes and commits it. When the token decoder signals an IN token for this endpoint, the block issues `pkt_start` with DATA0, DATA1, NAK or STALL, serves payload bytes through the transmitter's avail/get pull interface, then waits for the host ACK. On ACK it flips the data toggle; on a timeout it keeps the packet for a retry.

---
 rtl/usb_in_ep_buffer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/usb_in_ep_buffer.sv
// rtl/usb_in_ep_buffer.sv - single-packet IN endpoint buffer with DATA0/DATA1/NAK/STALL sequencing
module usb_in_ep_buffer #(
  parameter int DEPTH       = 64,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       wr_commit,
  output logic       wr_ready,
  output logic       wr_overflow,
  input  logic       in_token,
  input  logic       ack_rcvd,
  input  logic       stall,
  input  logic       clear_toggle,
  output logic       pkt_start,
  output logic [3:0] pid,
  input  logic       pkt_end,
  output logic       tx_data_avail,
  input  logic       tx_data_get,
  output logic [7:0] tx_data,
  output logic       pkt_sent
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [TW-1:0] TMR_MAX = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    S_EMPTY,
    S_FULL,
    S_SEND_HS,
    S_SEND_DATA,
    S_WAIT_ACK
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, len, rd_next;
  logic [AW-1:0] rd_addr;
  logic [TW-1:0] timer;
  logic          toggle, hs_to_full, retry_pend;

  logic          wr_accept, wr_drop, token_full, start_c, ack_take, timeout, hs_to_full_c;
  logic [3:0]    pid_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_c      = 1'b0;
    pid_c        = pid;
    hs_to_full_c = hs_to_full;
    token_full   = 1'b0;
    ack_take     = 1'b0;
    wr_accept    = 1'b0;
    wr_drop      = 1'b0;
    timeout      = (timer == TMR_MAX);
    unique case (state)
      S_EMPTY: begin
        wr_accept = wr_en && (wr_ptr != PTR_MAX);
        wr_drop   = wr_en && (wr_ptr == PTR_MAX);
        // A commit landing with the token is NAKed now and served on the next token.
        if (in_token) begin
          state_nxt    = S_SEND_HS;
          start_c      = 1'b1;
          pid_c        = stall ? PID_STALL : PID_NAK;
          hs_to_full_c = wr_commit;
        end else if (wr_commit) begin
          state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (in_token || retry_pend) begin
          start_c = 1'b1;
          if (stall) begin
            state_nxt    = S_SEND_HS;
            pid_c        = PID_STALL;
            hs_to_full_c = 1'b1;
          end else begin
            state_nxt  = S_SEND_DATA;
            pid_c      = toggle ? PID_DATA1 : PID_DATA0;
            token_full = 1'b1;
          end
        end
      end
      S_SEND_HS: begin
        if (pkt_end) state_nxt = hs_to_full ? S_FULL : S_EMPTY;
      end
      S_SEND_DATA: begin
        if (pkt_end) state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack_rcvd) begin
          ack_take  = 1'b1;
          state_nxt = S_EMPTY;
        end else if (timeout || in_token) begin
          state_nxt = S_FULL;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // Read pointer as it will be after this edge; the presented byte is registered from it.
  always_comb begin
    rd_next = rd_ptr;
    if (token_full)
      rd_next = '0;
    else if ((state == S_SEND_DATA) && tx_data_get && tx_data_avail)
      rd_next = rd_ptr + PTR_ONE;
    rd_addr = rd_next[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      len           <= '0;
      timer         <= '0;
      toggle        <= 1'b0;
      hs_to_full    <= 1'b0;
      retry_pend    <= 1'b0;
      wr_ready      <= 1'b1;
      wr_overflow   <= 1'b0;
      pkt_start     <= 1'b0;
      pid           <= 4'b0000;
      tx_data_avail <= 1'b0;
      tx_data       <= 8'h00;
      pkt_sent      <= 1'b0;
    end else begin
      if (wr_accept)     wr_ptr <= wr_ptr + PTR_ONE;
      else if (ack_take) wr_ptr <= '0;

      if ((state == S_EMPTY) && wr_commit)
        len <= wr_accept ? (wr_ptr + PTR_ONE) : wr_ptr;

      rd_ptr <= rd_next;

      if ((state == S_SEND_DATA) && pkt_end)
        timer <= '0;
      else if ((state == S_WAIT_ACK) && (timer != TMR_MAX))
        timer <= timer + TMR_ONE;

      if (clear_toggle)  toggle <= 1'b0;
      else if (ack_take) toggle <= ~toggle;

      hs_to_full <= hs_to_full_c;

      // A token that cuts the ACK wait short is replayed once the block is back in FULL.
      if ((state == S_WAIT_ACK) && !ack_rcvd && in_token) retry_pend <= 1'b1;
      else if (state == S_FULL)                          retry_pend <= 1'b0;

      wr_ready    <= (state_nxt == S_EMPTY);
      wr_overflow <= wr_drop;
      pkt_start   <= start_c;
      pid         <= pid_c;
      pkt_sent    <= ack_take;

      if ((state == S_SEND_DATA) && (state_nxt == S_SEND_DATA)) begin
        tx_data_avail <= (rd_next != len);
        tx_data       <= mem[rd_addr];
      end else begin
        tx_data_avail <= 1'b0;
        tx_data       <= 8'h00;
      end
    end
  end
endmodule
